// File: rtl/sorter_pkg.sv
// Shared types and helpers for the streaming odd-even transposition sorter.
package sorter_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SORT   = 2'd1,
    UNLOAD = 2'd2
  } sort_state_e;

  localparam logic ORDER_ASC  = 1'b0;
  localparam logic ORDER_DESC = 1'b1;

  // Width needed to hold a key count from 0 up to and including depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width needed to address one of depth slots (never narrower than one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sorter_cmp_swap.sv
// Combinational compare-exchange cell: routes an (a, b) slot pair onto the
// low and high positions of the network, honouring the occupied flags.
module sorter_cmp_swap
  import sorter_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic [DATA_W-1:0] a_key,
  input  logic              a_occ,
  input  logic [DATA_W-1:0] b_key,
  input  logic              b_occ,
  input  logic              order,
  output logic [DATA_W-1:0] lo_key,
  output logic              lo_occ,
  output logic [DATA_W-1:0] hi_key,
  output logic              hi_occ
);

  logic a_gt_b;
  logic a_lt_b;
  logic swap;

  // Key magnitude comparison at full key width, signed or unsigned by build.
  always_comb begin
    a_gt_b = 1'b0;
    a_lt_b = 1'b0;
    if (SIGNED_CMP) begin
      a_gt_b = $signed(a_key) > $signed(b_key);
      a_lt_b = $signed(a_key) < $signed(b_key);
    end else begin
      a_gt_b = a_key > b_key;
      a_lt_b = a_key < b_key;
    end
  end

  // Empty slots drift toward the high index; occupied pairs swap only when strictly out of order.
  always_comb begin
    swap = 1'b0;
    if (!a_occ && b_occ) begin
      swap = 1'b1;
    end else if (a_occ && b_occ) begin
      swap = (order == ORDER_ASC) ? a_gt_b : a_lt_b;
    end
    lo_key = swap ? b_key : a_key;
    lo_occ = swap ? b_occ : a_occ;
    hi_key = swap ? a_key : b_key;
    hi_occ = swap ? a_occ : b_occ;
  end

endmodule

// File: rtl/sorter_stream_oet.sv
// Streaming odd-even transposition sorter: loads up to DEPTH keys, sorts them
// in place over DEPTH phases, then streams them out in the latched order.
module sorter_stream_oet
  import sorter_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 8,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  input  logic                       order,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int IDX_W = idx_width(DEPTH);
  localparam int NCELL = DEPTH / 2;

  sort_state_e state;
  sort_state_e state_next;

  logic [DATA_W-1:0] slot_key [DEPTH];
  logic              slot_occ [DEPTH];
  logic [DATA_W-1:0] net_key  [DEPTH];
  logic              net_occ  [DEPTH];

  logic [DATA_W-1:0] ca_key [NCELL];
  logic              ca_occ [NCELL];
  logic [DATA_W-1:0] cb_key [NCELL];
  logic              cb_occ [NCELL];
  logic [DATA_W-1:0] lo_key [NCELL];
  logic              lo_occ [NCELL];
  logic [DATA_W-1:0] hi_key [NCELL];
  logic              hi_occ [NCELL];

  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] phase;
  logic             order_q;
  logic             odd_phase;
  logic             rd_is_last;
  logic             phase_last;

  assign count      = count_q;
  assign odd_phase  = phase[0];
  assign phase_last = (phase == IDX_W'(DEPTH - 1));
  assign rd_is_last = (CNT_W'(rd_idx) == (count_q - CNT_W'(1)));

  // Compare-exchange cells; odd phases shift each cell up by one slot where a partner exists.
  for (genvar i = 0; i < NCELL; i++) begin : g_cell
    if (2 * i + 2 < DEPTH) begin : g_mux
      assign ca_key[i] = odd_phase ? slot_key[2*i+1] : slot_key[2*i];
      assign ca_occ[i] = odd_phase ? slot_occ[2*i+1] : slot_occ[2*i];
      assign cb_key[i] = odd_phase ? slot_key[2*i+2] : slot_key[2*i+1];
      assign cb_occ[i] = odd_phase ? slot_occ[2*i+2] : slot_occ[2*i+1];
    end else begin : g_even_only
      assign ca_key[i] = slot_key[2*i];
      assign ca_occ[i] = slot_occ[2*i];
      assign cb_key[i] = slot_key[2*i+1];
      assign cb_occ[i] = slot_occ[2*i+1];
    end

    sorter_cmp_swap #(
      .DATA_W     (DATA_W),
      .SIGNED_CMP (SIGNED_CMP)
    ) u_cmp_swap (
      .a_key  (ca_key[i]),
      .a_occ  (ca_occ[i]),
      .b_key  (cb_key[i]),
      .b_occ  (cb_occ[i]),
      .order  (order_q),
      .lo_key (lo_key[i]),
      .lo_occ (lo_occ[i]),
      .hi_key (hi_key[i]),
      .hi_occ (hi_occ[i])
    );
  end

  // Per-slot result of one phase; edge slots without a partner keep their value.
  for (genvar j = 0; j < DEPTH; j++) begin : g_slot
    logic [DATA_W-1:0] ev_key;
    logic              ev_occ;
    logic [DATA_W-1:0] od_key;
    logic              od_occ;

    if ((j % 2 == 0) && (j + 1 < DEPTH)) begin : g_ev_lo
      assign ev_key = lo_key[j/2];
      assign ev_occ = lo_occ[j/2];
    end else if (j % 2 == 1) begin : g_ev_hi
      assign ev_key = hi_key[(j-1)/2];
      assign ev_occ = hi_occ[(j-1)/2];
    end else begin : g_ev_hold
      assign ev_key = slot_key[j];
      assign ev_occ = slot_occ[j];
    end

    if ((j % 2 == 1) && (j + 1 < DEPTH)) begin : g_od_lo
      assign od_key = lo_key[(j-1)/2];
      assign od_occ = lo_occ[(j-1)/2];
    end else if ((j % 2 == 0) && (j >= 2)) begin : g_od_hi
      assign od_key = hi_key[(j-2)/2];
      assign od_occ = hi_occ[(j-2)/2];
    end else begin : g_od_hold
      assign od_key = slot_key[j];
      assign od_occ = slot_occ[j];
    end

    assign net_key[j] = odd_phase ? od_key : ev_key;
    assign net_occ[j] = odd_phase ? od_occ : ev_occ;
  end

  // State register; reset abandons whatever frame is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and stream handshake outputs, all derived from the current state.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = '0;
    busy       = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (in_last || (count_q == CNT_W'(DEPTH - 1)))) begin
          state_next = SORT;
        end
      end
      SORT: begin
        busy = 1'b1;
        if (phase_last) begin
          state_next = UNLOAD;
        end
      end
      UNLOAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = slot_key[rd_idx];
        out_last  = rd_is_last;
        if (out_ready && rd_is_last) begin
          state_next = LOAD;
        end
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // Slot storage, frame count, sort phase and read pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      rd_idx  <= '0;
      phase   <= '0;
      order_q <= ORDER_ASC;
      for (int j = 0; j < DEPTH; j++) begin
        slot_key[j] <= '0;
        slot_occ[j] <= 1'b0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            slot_key[count_q[IDX_W-1:0]] <= in_data;
            slot_occ[count_q[IDX_W-1:0]] <= 1'b1;
            count_q <= count_q + CNT_W'(1);
            phase   <= '0;
            if (count_q == '0) begin
              order_q <= order;
            end
          end
        end
        SORT: begin
          for (int j = 0; j < DEPTH; j++) begin
            slot_key[j] <= net_key[j];
            slot_occ[j] <= net_occ[j];
          end
          phase <= phase_last ? '0 : (phase + IDX_W'(1));
        end
        UNLOAD: begin
          if (out_ready) begin
            if (rd_is_last) begin
              count_q <= '0;
              rd_idx  <= '0;
              for (int j = 0; j < DEPTH; j++) begin
                slot_occ[j] <= 1'b0;
              end
            end else begin
              rd_idx <= rd_idx + IDX_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sorter_stream_oet.sv
// Directed bench for sorter_stream_oet: an unsigned and a signed build run the
// same stimulus side by side, each checked against its own expected-key queue.
module tb_sorter_stream_oet;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       order;
  logic       out_ready;

  logic [7:0] out_data_u;
  logic       out_valid_u;
  logic       out_last_u;
  logic       in_ready_u;
  logic       busy_u;
  logic [3:0] count_u;

  logic [7:0] out_data_s;
  logic       out_valid_s;
  logic       out_last_s;
  logic       in_ready_s;
  logic       busy_s;
  logic [3:0] count_s;

  int checks;
  int errors;

  logic [7:0] sb_u[$];
  logic [7:0] sb_s[$];

  sorter_stream_oet #(.DATA_W(8), .DEPTH(8), .SIGNED_CMP(1'b0)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready_u),
    .order     (order),
    .out_data  (out_data_u),
    .out_valid (out_valid_u),
    .out_last  (out_last_u),
    .out_ready (out_ready),
    .busy      (busy_u),
    .count     (count_u)
  );

  sorter_stream_oet #(.DATA_W(8), .DEPTH(8), .SIGNED_CMP(1'b1)) u_dut_signed (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready_s),
    .order     (order),
    .out_data  (out_data_s),
    .out_valid (out_valid_s),
    .out_last  (out_last_s),
    .out_ready (out_ready),
    .busy      (busy_s),
    .count     (count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // True when key a must be emitted strictly before key b.
  function automatic bit keyBefore(input logic [7:0] a, input logic [7:0] b,
                                   input logic ord, input bit sgn);
    bit lt;
    bit gt;
    lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
    gt = sgn ? ($signed(a) > $signed(b)) : (a > b);
    return ord ? gt : lt;
  endfunction

  // Stable insertion sort of the first n keys.
  task automatic modelSort(input logic [7:0] k[8], input int n, input logic ord,
                           input bit sgn, output logic [7:0] r[8]);
    logic [7:0] t;
    r = k;
    for (int i = 1; i < n; i++) begin
      for (int j = i; j > 0; j--) begin
        if (keyBefore(r[j], r[j-1], ord, sgn)) begin
          t      = r[j];
          r[j]   = r[j-1];
          r[j-1] = t;
        end
      end
    end
  endtask

  // Pushes expected keys, then drives the frame one key per cycle.
  task automatic applyStimulus(input logic [7:0] k[8], input int n, input logic ord);
    logic [7:0] ru[8];
    logic [7:0] rs[8];
    modelSort(k, n, ord, 1'b0, ru);
    modelSort(k, n, ord, 1'b1, rs);
    for (int i = 0; i < n; i++) begin
      sb_u.push_back(ru[i]);
      sb_s.push_back(rs[i]);
    end
    for (int i = 0; i < n; i++) begin
      in_data  = k[i];
      in_valid = 1'b1;
      in_last  = (i == n - 1);
      order    = ord;
      @(negedge clk);
      checkOutput("in_ready_load", in_ready_u, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  // Counts cycles from the last accept to the first out_valid while pushing junk at the input.
  task automatic waitFirstValid(input int expect_k);
    int  k;
    bit  found;
    k     = 0;
    found = 1'b0;
    out_ready = 1'b0;
    while (!found && k < 40) begin
      k++;
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = 8'hAA;
      @(negedge clk);
      if (k == 1) begin
        checkOutput("busy_sort", busy_u, 1);
        checkOutput("in_ready_sort", in_ready_u, 0);
      end
      if (out_valid_u) begin
        found = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    checkOutput("first_valid_latency", k, expect_k);
    @(posedge clk);
    #1;
  endtask

  // Pops and compares every handshaken key; bp selects the 1,0,0 ready pattern.
  task automatic drainFrame(input int n, input bit bp);
    int         got;
    int         budget;
    int         step;
    bit         stalled;
    logic [7:0] prev_data;
    logic       prev_last;
    got       = 0;
    budget    = 0;
    step      = 0;
    stalled   = 1'b0;
    prev_data = 8'h00;
    prev_last = 1'b0;
    out_ready = 1'b1;
    while (got < n && budget < 100) begin
      @(negedge clk);
      if (out_valid_u) begin
        if (stalled) begin
          checkOutput("stall_hold_data", out_data_u, prev_data);
          checkOutput("stall_hold_last", out_last_u, prev_last);
        end
        checkOutput("in_ready_unload", in_ready_u, 0);
        checkOutput("count_unload", count_u, n);
        checkOutput("data_u", out_data_u, (sb_u.size() > 0) ? sb_u[0] : 8'hXX);
        checkOutput("last_u", out_last_u, (got == n - 1));
        checkOutput("valid_s", out_valid_s, 1);
        checkOutput("data_s", out_data_s, (sb_s.size() > 0) ? sb_s[0] : 8'hXX);
        checkOutput("last_s", out_last_s, (got == n - 1));
        if (out_ready) begin
          if (sb_u.size() > 0) void'(sb_u.pop_front());
          if (sb_s.size() > 0) void'(sb_s.pop_front());
          got++;
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          prev_data = out_data_u;
          prev_last = out_last_u;
        end
      end
      @(posedge clk);
      #1;
      budget++;
      step++;
      out_ready = bp ? ((step % 3) == 0) : 1'b1;
    end
    out_ready = 1'b0;
    checkOutput("drain_count", got, n);
    @(negedge clk);
    checkOutput("in_ready_after", in_ready_u, 1);
    checkOutput("out_valid_after", out_valid_u, 0);
    checkOutput("count_after", count_u, 0);
    checkOutput("busy_after", busy_u, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] frame[8];
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    order     = 1'b0;
    out_ready = 1'b0;

    $display("[TB] reset state");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready_u, 1);
    checkOutput("rst_out_valid", out_valid_u, 0);
    checkOutput("rst_out_last", out_last_u, 0);
    checkOutput("rst_out_data", out_data_u, 0);
    checkOutput("rst_busy", busy_u, 0);
    checkOutput("rst_count", count_u, 0);
    @(posedge clk);
    #1;

    $display("[TB] full frame ascending");
    frame = '{8'h37, 8'h05, 8'hFF, 8'h00, 8'h80, 8'h05, 8'h7E, 8'h01};
    applyStimulus(frame, 8, 1'b0);
    waitFirstValid(9);
    drainFrame(8, 1'b0);

    $display("[TB] full frame descending");
    applyStimulus(frame, 8, 1'b1);
    waitFirstValid(9);
    drainFrame(8, 1'b0);

    $display("[TB] short frame");
    frame = '{8'h09, 8'h03, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(frame, 3, 1'b0);
    waitFirstValid(9);
    drainFrame(3, 1'b0);

    $display("[TB] single key frame");
    frame = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(frame, 1, 1'b0);
    waitFirstValid(9);
    drainFrame(1, 1'b0);

    $display("[TB] backpressure");
    frame = '{8'hC3, 8'h12, 8'h12, 8'hF0, 8'h44, 8'h9A, 8'h00, 8'h7F};
    applyStimulus(frame, 8, 1'b0);
    waitFirstValid(9);
    drainFrame(8, 1'b1);

    $display("[TB] reset during sort");
    frame = '{8'h44, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(frame, 4, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("busy_phase3", busy_u, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_u.delete();
    sb_s.delete();
    @(negedge clk);
    checkOutput("midrst_in_ready", in_ready_u, 1);
    checkOutput("midrst_out_valid", out_valid_u, 0);
    checkOutput("midrst_count", count_u, 0);
    @(posedge clk);
    #1;
    frame = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(frame, 2, 1'b0);
    waitFirstValid(9);
    drainFrame(2, 1'b0);

    $display("[TB] signed compare frame");
    frame = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(frame, 4, 1'b0);
    waitFirstValid(9);
    drainFrame(4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
